// File: rtl/clk_mgr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_mgr_pkg
// Brief    : Shared types and helpers for the clock-manager controller.
// Revision : 1.0 - initial release
// ============================================================================
package clk_mgr_pkg;

  // Sequencer states; the numeric encoding is visible on state_o.
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Width able to hold 0..max_val inclusive, with one bit of headroom.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mgr_ctrl_ce_div.sv
`default_nettype none
// ============================================================================
// Module   : ce_div
// Brief    : One clock-enable channel. A shadow divisor is loaded on request
//            and copied into the active divisor only at a period boundary or
//            while the channel is held in reset, so periods never shrink
//            below min(old, new).
// Revision : 1.0 - initial release
// ============================================================================
module ce_div
  import clk_mgr_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             upd_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] shadow_q;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] cnt_q;
  logic             w_short;
  logic             w_wrap;
  logic [DIV_W-1:0] w_next_div;

  // Wrap detection; an update arriving on a wrap cycle is forwarded straight
  // into the active divisor so it governs the very next period.
  always_comb begin
    w_short    = (active_q <= DIV_ONE);
    w_wrap     = w_short || (cnt_q == (active_q - DIV_ONE));
    w_next_div = upd_i ? div_i : shadow_q;
  end

  assign ce_o = en_i & w_wrap;

  // Shadow capture, active reload at period boundaries, and period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DIV_ONE;
      active_q <= DIV_ONE;
      cnt_q    <= '0;
    end else begin
      if (upd_i) begin
        shadow_q <= div_i;
      end
      if (!en_i || w_wrap) begin
        cnt_q    <= '0;
        active_q <= w_next_div;
      end else begin
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_mgr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_mgr_ctrl
// Brief    : rPLL sequencing/monitoring controller: PLL reset pulses, lock
//            filtering with timeout retry, staggered per-domain reset release
//            and N programmable clock-enable channels.
// Revision : 1.0 - initial release
// ============================================================================
module clk_mgr_ctrl
  import clk_mgr_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DIV_W     = 8,
  parameter int RST_CYC   = 16,
  parameter int LOCK_FILT = 64,
  parameter int LOCK_TO   = 65536,
  parameter int STAGE_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock_i,
  input  logic [N_CH*DIV_W-1:0] div_val_i,
  input  logic                  div_upd_i,
  output logic                  pll_rst_o,
  output logic                  locked_o,
  output logic [N_CH-1:0]       rst_n_o,
  output logic [N_CH-1:0]       ce_o,
  output logic [1:0]            state_o,
  output logic [7:0]            retry_cnt_o
);

  localparam int RW = cnt_w(RST_CYC);
  localparam int FW = cnt_w(LOCK_FILT);
  localparam int TW = cnt_w(LOCK_TO);
  localparam int SW = cnt_w(STAGE_CYC);

  localparam logic [RW-1:0]   RST_LAST  = RW'(RST_CYC - 1);
  localparam logic [FW-1:0]   FILT_MAX  = FW'(LOCK_FILT);
  localparam logic [TW-1:0]   TO_LAST   = TW'(LOCK_TO - 1);
  localparam logic [SW-1:0]   STG_LAST  = SW'(STAGE_CYC - 1);
  localparam logic [N_CH-1:0] FIRST_REL = N_CH'(1);

  logic            lock_meta_q;
  logic            lock_s_q;
  state_e          state_q;
  logic            pll_rst_q;
  logic            locked_q;
  logic [N_CH-1:0] rst_n_q;
  logic [7:0]      retry_q;
  logic [RW-1:0]   rst_cnt_q;
  logic [FW-1:0]   filt_q;
  logic [TW-1:0]   to_cnt_q;
  logic [SW-1:0]   stg_cnt_q;
  logic            w_lock_ok;
  logic            w_timeout;
  logic            w_loss;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Conditions that send the sequencer back to RESET_PLL; lock_ok beats timeout.
  always_comb begin
    w_lock_ok = (filt_q == FILT_MAX);
    w_timeout = (state_q == WAIT_LOCK) && !w_lock_ok && (to_cnt_q == TO_LAST);
    w_loss    = ((state_q == STAGGER) || (state_q == RUN)) && !lock_s_q;
  end

  // Sequencer with registered outputs, lock filter and all timing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      pll_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      rst_n_q   <= '0;
      retry_q   <= '0;
      rst_cnt_q <= '0;
      filt_q    <= '0;
      to_cnt_q  <= '0;
      stg_cnt_q <= '0;
    end else begin
      if (!lock_s_q) begin
        filt_q <= '0;
      end else if (filt_q != FILT_MAX) begin
        filt_q <= filt_q + 1'b1;
      end

      if (w_timeout || w_loss) begin
        state_q   <= RESET_PLL;
        pll_rst_q <= 1'b1;
        locked_q  <= 1'b0;
        rst_n_q   <= '0;
        retry_q   <= (retry_q == 8'hFF) ? retry_q : retry_q + 1'b1;
        rst_cnt_q <= '0;
        filt_q    <= '0;
        to_cnt_q  <= '0;
      end else begin
        case (state_q)
          RESET_PLL: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= WAIT_LOCK;
              pll_rst_q <= 1'b0;
              rst_cnt_q <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_q + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (w_lock_ok) begin
              state_q   <= STAGGER;
              locked_q  <= 1'b1;
              rst_n_q   <= FIRST_REL;
              stg_cnt_q <= '0;
              to_cnt_q  <= '0;
            end else begin
              to_cnt_q  <= to_cnt_q + 1'b1;
            end
          end
          STAGGER: begin
            // Releases form a thermometer code, so the top bit marks completion.
            if (rst_n_q[N_CH-1]) begin
              state_q   <= RUN;
            end else if (stg_cnt_q == STG_LAST) begin
              stg_cnt_q <= '0;
              rst_n_q   <= (rst_n_q << 1) | FIRST_REL;
            end else begin
              stg_cnt_q <= stg_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign locked_o    = locked_q;
  assign rst_n_o     = rst_n_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ce_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (rst_n_q[k]),
      .upd_i (div_upd_i),
      .div_i (div_val_i[k*DIV_W +: DIV_W]),
      .ce_o  (ce_o[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_mgr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_mgr_ctrl
// Brief    : Scoreboard bench for clk_mgr_ctrl. Stimulus pushes expected
//            output-change events and ce_o[0] pulse cycles; a monitor pops and
//            compares them whenever the DUT outputs change or ce_o[0] fires.
//            Cycle n is the interval after the n-th rising edge following
//            reset release (cycle 0 is the interval right after release).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_mgr_ctrl;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  pll_lock_i = 1'b0;
  logic [N_CH*DIV_W-1:0] div_val_i = '0;
  logic                  div_upd_i = 1'b0;
  logic                  pll_rst_o;
  logic                  locked_o;
  logic [N_CH-1:0]       rst_n_o;
  logic [N_CH-1:0]       ce_o;
  logic [1:0]            state_o;
  logic [7:0]            retry_cnt_o;

  always #10 clk = ~clk;

  clk_mgr_ctrl #(
    .N_CH      (N_CH),
    .DIV_W     (DIV_W),
    .RST_CYC   (16),
    .LOCK_FILT (64),
    .LOCK_TO   (200),
    .STAGE_CYC (256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock_i),
    .div_val_i   (div_val_i),
    .div_upd_i   (div_upd_i),
    .pll_rst_o   (pll_rst_o),
    .locked_o    (locked_o),
    .rst_n_o     (rst_n_o),
    .ce_o        (ce_o),
    .state_o     (state_o),
    .retry_cnt_o (retry_cnt_o)
  );

  typedef struct {
    int          cyc;
    logic [16:0] val;
  } evt_t;

  evt_t        exp_q[$];
  int          ce_q[$];
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          chk_seq = 0;
  int          chk_done = 0;
  logic [16:0] prev = '0;

  // {state, pll_rst, locked, rst_n[2:0], ce[2:1], retry}
  function automatic logic [16:0] mk(input logic [1:0] st, input logic pll,
                                     input logic lk, input logic [2:0] rn,
                                     input logic [1:0] ce21, input logic [7:0] rt);
    return {st, pll, lk, rn, ce21, rt};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: compares on every output change, every ce_o[0] pulse, and
  // checks that no expectation is left over when a phase ends.
  always @(negedge clk) begin : mon
    logic [16:0] cur;
    evt_t        e;
    int          ec;
    if (rst_n) begin
      cur = {state_o, pll_rst_o, locked_o, rst_n_o, ce_o[2:1], retry_cnt_o};
      if (cyc == 0 || cur != prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL evt unexpected: actual cyc=%0d val=%h required no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val != cur) begin
            n_bad++;
            $display("FAIL evt: actual cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.val);
          end
        end
      end
      prev = cur;
      if (ce_o[0]) begin
        n_cmp++;
        if (ce_q.size() == 0) begin
          n_bad++;
          $display("FAIL ce0 unexpected: actual pulse at cyc=%0d required none", cyc);
        end else begin
          ec = ce_q.pop_front();
          if (ec != cyc) begin
            n_bad++;
            $display("FAIL ce0: actual pulse at cyc=%0d required cyc=%0d", cyc, ec);
          end
        end
      end
    end
    if (chk_seq != chk_done) begin
      chk_done = chk_seq;
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL evt missing: actual pending=%0d required 0 (next cyc=%0d)",
                 exp_q.size(), exp_q[0].cyc);
      end
      n_cmp++;
      if (ce_q.size() != 0) begin
        n_bad++;
        $display("FAIL ce0 missing: actual pending=%0d required 0 (next cyc=%0d)",
                 ce_q.size(), ce_q[0]);
      end
      exp_q.delete();
      ce_q.delete();
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_phase();
    rst_n      = 1'b0;
    pll_lock_i = 1'b0;
    div_upd_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('{cyc: 0, val: mk(2'd0, 1'b1, 1'b0, 3'b000, 2'b00, 8'd0)});
    rst_n = 1'b1;
  endtask

  task automatic end_phase();
    chk_seq++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Nominal bring-up, divisors {ch2=0, ch1=1, ch0=5}, update 5->3, lock loss.
    start_phase();
    exp_q.push_back('{cyc: 16,  val: mk(2'd1, 1'b0, 1'b0, 3'b000, 2'b00, 8'd0)});
    exp_q.push_back('{cyc: 166, val: mk(2'd2, 1'b0, 1'b1, 3'b001, 2'b00, 8'd0)});
    exp_q.push_back('{cyc: 422, val: mk(2'd2, 1'b0, 1'b1, 3'b011, 2'b01, 8'd0)});
    exp_q.push_back('{cyc: 678, val: mk(2'd2, 1'b0, 1'b1, 3'b111, 2'b11, 8'd0)});
    exp_q.push_back('{cyc: 679, val: mk(2'd3, 1'b0, 1'b1, 3'b111, 2'b11, 8'd0)});
    exp_q.push_back('{cyc: 723, val: mk(2'd0, 1'b1, 1'b0, 3'b000, 2'b00, 8'd1)});
    exp_q.push_back('{cyc: 739, val: mk(2'd1, 1'b0, 1'b0, 3'b000, 2'b00, 8'd1)});
    exp_q.push_back('{cyc: 939, val: mk(2'd0, 1'b1, 1'b0, 3'b000, 2'b00, 8'd2)});
    // ch0 released in cycle 166: pulses on its 5th cycle, period 5 until the
    // update lands at the wrap in 705, then period 3 until lock loss in 723.
    for (int c = 170; c <= 705; c += 5) ce_q.push_back(c);
    for (int c = 708; c <= 720; c += 3) ce_q.push_back(c);
    at_cyc(2);
    div_val_i = {8'd0, 8'd1, 8'd5};
    div_upd_i = 1'b1;
    at_cyc(3);
    div_upd_i = 1'b0;
    at_cyc(99);
    pll_lock_i = 1'b1;
    at_cyc(702);
    div_val_i = {8'd0, 8'd1, 8'd3};
    div_upd_i = 1'b1;
    at_cyc(703);
    div_upd_i = 1'b0;
    at_cyc(720);
    pll_lock_i = 1'b0;
    at_cyc(945);
    end_phase();

    // Filter glitch: 40 high, 1 low, then high; 64 fresh cycles needed.
    start_phase();
    exp_q.push_back('{cyc: 16,  val: mk(2'd1, 1'b0, 1'b0, 3'b000, 2'b00, 8'd0)});
    exp_q.push_back('{cyc: 207, val: mk(2'd2, 1'b0, 1'b1, 3'b001, 2'b00, 8'd0)});
    for (int c = 207; c <= 210; c++) ce_q.push_back(c);
    at_cyc(99);
    pll_lock_i = 1'b1;
    at_cyc(139);
    pll_lock_i = 1'b0;
    at_cyc(140);
    pll_lock_i = 1'b1;
    at_cyc(210);
    end_phase();

    // lock_ok on the last timeout cycle: lock wins, no retry.
    start_phase();
    exp_q.push_back('{cyc: 16,  val: mk(2'd1, 1'b0, 1'b0, 3'b000, 2'b00, 8'd0)});
    exp_q.push_back('{cyc: 216, val: mk(2'd2, 1'b0, 1'b1, 3'b001, 2'b00, 8'd0)});
    ce_q.push_back(216);
    at_cyc(149);
    pll_lock_i = 1'b1;
    at_cyc(216);
    end_phase();

    // Lock never arrives: re-pulse every 16+200 cycles, retry saturates.
    start_phase();
    for (int p = 1; p <= 256; p++) begin
      exp_q.push_back('{cyc: 16 + 216*(p-1),
                        val: mk(2'd1, 1'b0, 1'b0, 3'b000, 2'b00, 8'((p-1 > 255) ? 255 : p-1))});
      exp_q.push_back('{cyc: 216*p,
                        val: mk(2'd0, 1'b1, 1'b0, 3'b000, 2'b00, 8'((p > 255) ? 255 : p))});
    end
    at_cyc(55300);
    end_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_mgr_ctrl.md
Name: clk_mgr_ctrl

Overview:
- Parametrised successor to the single-output rPLL wrapper: sequencing and monitoring controller that sits next to the rPLL primitive in each clock domain.
- Runs on the 50 MHz board reference clock.
- Drives the PLL reset and filters the asynchronous PLL LOCK.
- Retries on lock timeout; releases N per-domain resets in staggered order.
- Generates N programmable clock-enable streams with glitch-free runtime divisor update.

Parameters:
- N_CH, 3: number of downstream domains / clock-enable channels.
- DIV_W, 8: width of each channel divisor.
- RST_CYC, 16: cycles pll_rst_o is held high per PLL reset attempt.
- LOCK_FILT, 64: consecutive cycles of synchronised lock required to declare lock.
- LOCK_TO, 65536: cycles allowed in WAIT_LOCK before retry.
- STAGE_CYC, 256: cycles between successive rst_n_o releases.

Ports:
- clk, in, 1: 50 MHz reference clock.
- rst_n, in, 1: asynchronous active-low reset.
- pll_lock_i, in, 1: raw rPLL LOCK, asynchronous to clk.
- div_val_i, in, N_CH*DIV_W: packed divisors; channel k is at [k*DIV_W +: DIV_W].
- div_upd_i, in, 1: single-cycle pulse that captures div_val_i into shadow registers.
- pll_rst_o, out, 1: active-high reset to the rPLL RESET pin.
- locked_o, out, 1: filtered lock, high only in STAGGER/RUN.
- rst_n_o, out, N_CH: per-domain active-low resets.
- ce_o, out, N_CH: per-channel clock-enable pulses.
- state_o, out, 2: FSM state (0 RESET_PLL, 1 WAIT_LOCK, 2 STAGGER, 3 RUN).
- retry_cnt_o, out, 8: saturating count of lock timeouts and lock losses.

Behaviour:
- Reset (rst_n low, async) values:
  - state RESET_PLL, pll_rst_o=1, locked_o=0, rst_n_o=0, ce_o=0, retry_cnt_o=0.
  - All counters 0; shadow and active divisors = 1.
- Lock input: pll_lock_i passes through a 2-flop synchroniser (lock_s). A filter counter increments while lock_s=1, clears to 0 when lock_s=0, and saturates at LOCK_FILT. lock_ok = (count == LOCK_FILT).
- RESET_PLL:
  - pll_rst_o=1 for exactly RST_CYC cycles, then go to WAIT_LOCK.
  - Filter and timeout counters are cleared on entry.
- WAIT_LOCK:
  - pll_rst_o=0.
  - If lock_ok: go to STAGGER.
  - Else if timeout counter reaches LOCK_TO-1: retry_cnt_o += 1 (saturates at 255), go to RESET_PLL.
  - If lock_ok and the timeout coincide, lock_ok wins.
- STAGGER:
  - locked_o=1.
  - rst_n_o[0] releases on the first STAGGER cycle.
  - rst_n_o[k] releases k*STAGE_CYC cycles later.
  - After rst_n_o[N_CH-1] is released, go to RUN next cycle.
  - Released bits stay high.
- RUN: hold all outputs steady.
- Lock loss (lock_s=0 in STAGGER or RUN):
  - Same cycle: locked_o drops and rst_n_o goes to all zeros.
  - ce_o is forced to 0 from that cycle.
  - retry_cnt_o += 1; go to RESET_PLL.
- Clock-enable channels:
  - Each channel has a counter of width DIV_W, active only while its rst_n_o[k]=1; otherwise the counter is held at 0 and ce_o[k]=0.
  - Divisor d ≤ 1: ce_o[k]=1 on every cycle.
  - Divisor d ≥ 2: counter runs 0..d-1, and ce_o[k]=1 on the cycle where counter == d-1, so the period is exactly d cycles.
  - The first pulse appears d cycles after release.
- Divisor update:
  - div_upd_i captures all shadows in one cycle.
  - Each channel copies its shadow into its active divisor only at its wrap cycle (counter == d-1, or every cycle if d ≤ 1), or while held in reset. No period is ever shorter than min(old, new).
  - If div_upd_i arrives on a wrap cycle, the old value applies for that wrap and the new value for the next.
- Counter widths: derive with $clog2 of the parameter +1. No wrap-around is permitted on any counter; all saturate or clear.

Decomposition:
- Package clk_mgr_pkg holds the state enum (RESET_PLL, WAIT_LOCK, STAGGER, RUN) and the helper function for counter widths.
- Sub-module ce_div: one divisor channel (shadow/active registers, counter, ce). Instantiate it N_CH times with generate.
- Synchroniser and FSM stay in the top level.

Test Plan:
- Nominal bring-up: pll_lock_i rises 100 cycles after reset release, N_CH=3, STAGE_CYC=256.
  - pll_rst_o is high for cycles 0-15.
  - locked_o rises 2+64 cycles after lock.
  - rst_n_o releases at offsets 0/256/512; state_o=3.
- Lock timeout: pll_lock_i held at 0, LOCK_TO=1000.
  - pll_rst_o re-pulses every 16+1000 cycles.
  - retry_cnt_o increments each pass and saturates at 255.
- Lock glitch in filter: lock high for 40 cycles, low for 1, high again.
  - No STAGGER entry until 64 consecutive synchronised-high cycles.
- Lock loss in RUN: drop pll_lock_i.
  - 2 synchroniser cycles later, rst_n_o=000, ce_o=000 and locked_o=0 in the same cycle.
  - state_o=0; retry_cnt_o+1.
- Divisors {5,1,0}:
  - ce_o[0] period is 5.
  - ce_o[1] and ce_o[2] are constantly high after release.
- Update 5 to 3 via div_upd_i mid-period (counter=1):
  - Current period completes at 5.
  - Subsequent periods are 3; no period under 3.
